// File: rtl/ram_rw_arbiter.sv
// Round-robin read/write arbiter sharing one single-port synchronous RAM between requesters A and B.
// Define ARB_STATS_EN to add per-requester grant counters (cnt_a/cnt_b) with a synchronous clear.
module ram_rw_arbiter #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef ARB_STATS_EN
    input  logic                  clr_stats,
    output logic [7:0]            cnt_a,
    output logic [7:0]            cnt_b,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, READ, RESP} state_e;

    state_e                state_q, state_d;
    logic                  win_b_q, win_b_d;
    logic                  last_b_q, last_b_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic                  pick_b;

    // B wins only when alone, or on a tie when A took the previous grant
    assign pick_b = req_b & (~req_a | ~last_b_q);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            win_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            win_b_q   <= win_b_d;
            last_b_q  <= last_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_b_d   = win_b_q;
        last_b_d  = last_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        unique case (state_q)
            IDLE: begin
                if (req_a | req_b) begin
                    state_d  = ISSUE;
                    win_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? we_b    : we_a;
                    addr_d   = pick_b ? addr_b  : addr_a;
                    wdata_d  = pick_b ? wdata_b : wdata_a;
                end
            end
            ISSUE: state_d = we_q ? IDLE : READ;
            READ: begin
                state_d = RESP;
                if (win_b_q) rdata_b_d = mem_rdata;
                else         rdata_a_d = mem_rdata;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        gnt_a     = (state_q == ISSUE) & ~win_b_q;
        gnt_b     = (state_q == ISSUE) &  win_b_q;
        rvalid_a  = (state_q == RESP)  & ~win_b_q;
        rvalid_b  = (state_q == RESP)  &  win_b_q;
        mem_we    = (state_q == ISSUE) &  we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata_a   = rdata_a_q;
        rdata_b   = rdata_b_q;
    end

`ifdef ARB_STATS_EN
    logic [7:0] cnt_a_q, cnt_b_q;

    // Clear takes priority over a grant in the same cycle
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else if (clr_stats) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            if (gnt_a) cnt_a_q <= cnt_a_q + 8'd1;
            if (gnt_b) cnt_b_q <= cnt_b_q + 8'd1;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Testbench for ram_rw_arbiter: directed scenarios plus random traffic against a
// transaction-level model (arbitration rule, reference memory, expected read data).
module tb_ram_rw_arbiter;

    localparam int AW = 2;
    localparam int DW = 4;

    logic          clk_2 = 1'b0;
    logic          reset;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
    logic          clr_stats;
    logic [7:0]    cnt_a, cnt_b;
`endif

    always #5 clk_2 = ~clk_2;

    ram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_2(clk_2), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
        .clr_stats(clr_stats), .cnt_a(cnt_a), .cnt_b(cnt_b),
`endif
        .busy(busy)
    );

    // Single-port RAM with registered read
    logic [DW-1:0] ram [0:3] = '{default: '0};
    always @(posedge clk_2) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    bit            last_b;
    logic [DW-1:0] ref_mem [0:3];
    logic [DW-1:0] exp_ra, exp_rb;
    int            exp_ca, exp_cb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic model_reset();
        last_b = 1'b1;
        exp_ra = '0;
        exp_rb = '0;
        exp_ca = 0;
        exp_cb = 0;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_gnt"}, {gnt_a, gnt_b}, 0);
        check({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 0);
        check({tag, "_rdata"}, {rdata_a, rdata_b}, 0);
        check({tag, "_mem"}, {mem_we, mem_addr, mem_wdata}, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef ARB_STATS_EN
        check({tag, "_cnt"}, {cnt_a, cnt_b}, 0);
`endif
    endtask

    // One full transaction (or one idle cycle) predicted from the inputs seen in IDLE
    task automatic run_round(input bit poke);
        bit            wb, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!req_a && !req_b) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_gnt", {gnt_a, gnt_b}, 0);
            return;
        end
        wb = req_b && (!req_a || !last_b);
        w  = wb ? we_b    : we_a;
        a  = wb ? addr_b  : addr_a;
        d  = wb ? wdata_b : wdata_a;
        step();
        check("gnt_a", gnt_a, !wb);
        check("gnt_b", gnt_b, wb);
        check("mem_we", mem_we, w);
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
        check("busy", busy, 1);
        last_b = wb;
        if (wb) exp_cb = (exp_cb + 1) % 256;
        else    exp_ca = (exp_ca + 1) % 256;
        if (poke) begin
            req_a  = 1'b1;
            we_a   = 1'b0;
            addr_a = 2'd1;
        end
        if (w) begin
            ref_mem[a] = d;
            step();
            check("wr_end_busy", busy, 0);
            check("wr_end_we", mem_we, 0);
        end else begin
            step();
            check("rd_busy", busy, 1);
            check("rd_gnt", {gnt_a, gnt_b}, 0);
            check("rd_we", mem_we, 0);
            check("rd_addr", mem_addr, a);
            if (poke) addr_a = 2'd3;
            step();
            if (wb) exp_rb = ref_mem[a];
            else    exp_ra = ref_mem[a];
            check("rvalid_a", rvalid_a, !wb);
            check("rvalid_b", rvalid_b, wb);
            check("rdata_a", rdata_a, exp_ra);
            check("rdata_b", rdata_b, exp_rb);
            step();
            check("resp_end_busy", busy, 0);
            check("resp_end_rvalid", {rvalid_a, rvalid_b}, 0);
        end
    endtask

    task automatic drop_winner();
        if (last_b) req_b = 1'b0;
        else        req_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {req_a, we_a, addr_a, wdata_a} = '0;
        {req_b, we_b, addr_b, wdata_b} = '0;
`ifdef ARB_STATS_EN
        clr_stats = 1'b0;
`endif
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        model_reset();
        #1;
        check_zero_outs("reset");
        step();
        reset = 1'b0;
        step();

        // A writes A to address 2, then B reads it back
        req_a = 1; we_a = 1; addr_a = 2; wdata_a = 4'hA;
        run_round(0);
        req_a = 0;
        req_b = 1; we_b = 0; addr_b = 2;
        run_round(0);
        req_b = 0;

        // Simultaneous writes to address 1, then A reads the later value
        req_a = 1; we_a = 1; addr_a = 1; wdata_a = 4'h3;
        req_b = 1; we_b = 1; addr_b = 1; wdata_b = 4'h5;
        run_round(0);
        drop_winner();
        run_round(0);
        drop_winner();
        req_a = 1; we_a = 0; addr_a = 1;
        run_round(0);
        req_a = 0;

        // Both held continuously: strict alternation
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 4'h7;
        req_b = 1; we_b = 1; addr_b = 3; wdata_b = 4'h9;
        for (int i = 0; i < 6; i++) run_round(0);
        req_a = 0; req_b = 0;

        // Reset while an A read is in READ
        req_a = 1; we_a = 0; addr_a = 1;
        step();
        step();
        reset = 1'b1;
        #1;
        check_zero_outs("mid_reset");
        req_a = 0;
        step();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_rvalid_after_reset", {rvalid_a, gnt_a, busy}, 0);
        end
        req_a = 1; we_a = 0; addr_a = 1;
        run_round(0);
        req_a = 0;

        // A's inputs change while B is busy; only the IDLE-time value counts
        req_b = 1; we_b = 0; addr_b = 2;
        run_round(1);
        req_b = 0;
        run_round(0);
        req_a = 0;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            if (!req_a && $urandom_range(0, 3) != 0) begin
                req_a = 1; we_a = 1'($urandom);
                addr_a = 2'($urandom); wdata_a = 4'($urandom);
            end
            if (!req_b && $urandom_range(0, 3) != 0) begin
                req_b = 1; we_b = 1'($urandom);
                addr_b = 2'($urandom); wdata_b = 4'($urandom);
            end
            run_round(0);
            if (busy == 1'b0 && (gnt_a | gnt_b | rvalid_a | rvalid_b) == 1'b0) begin
                if ($urandom_range(0, 1) == 0) drop_winner();
                else if (last_b) begin
                    we_b = 1'($urandom); addr_b = 2'($urandom); wdata_b = 4'($urandom);
                end else begin
                    we_a = 1'($urandom); addr_a = 2'($urandom); wdata_a = 4'($urandom);
                end
            end
        end
        req_a = 0; req_b = 0;
        step();

`ifdef ARB_STATS_EN
        check("cnt_a_rand", cnt_a, exp_ca);
        check("cnt_b_rand", cnt_b, exp_cb);
        clr_stats = 1;
        step();
        clr_stats = 0;
        check("clr_cnt_a", cnt_a, 0);
        check("clr_cnt_b", cnt_b, 0);
        req_a = 1; we_a = 1;
        for (int n = 0; n < 300; n++) begin
            addr_a = 2'($urandom); wdata_a = 4'($urandom);
            run_round(0);
        end
        req_a = 0;
        step();
        check("cnt_a_300", cnt_a, 44);
        check("cnt_b_300", cnt_b, 0);
        clr_stats = 1;
        step();
        clr_stats = 0;
        check("clr2_cnt_a", cnt_a, 0);
        check("clr2_cnt_b", cnt_b, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_rw_arbiter.md
Name: ram_rw_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port 4-word x 4-bit synchronous RAM between two requesters, A and B.
- Each requester issues a read or write with a req/gnt handshake. Read data returns through a per-requester rvalid pulse.
- The block sits between the switch/LED front-end logic and the RAM. It drives the RAM's write-enable, address and write-data inputs and samples its registered read output.

Parameters:
- ADDR_WIDTH, 2: RAM address width; the RAM holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 4: RAM word width.

Ports:
- clk_2, in, 1: single clock; all state updates on posedge.
- reset, in, 1: asynchronous, active-high reset.
- req_a, in, 1: requester A access request.
- we_a, in, 1: A access type, 1 = write, 0 = read.
- addr_a, in, ADDR_WIDTH: A address.
- wdata_a, in, DATA_WIDTH: A write data.
- gnt_a, out, 1: one-cycle pulse; A's request has been issued to the RAM.
- rvalid_a, out, 1: one-cycle pulse; rdata_a is valid.
- rdata_a, out, DATA_WIDTH: A read data; holds its value until the next A read.
- req_b / we_b / addr_b / wdata_b / gnt_b / rvalid_b / rdata_b: same as the A ports, for requester B.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_WIDTH: RAM address.
- mem_wdata, out, DATA_WIDTH: RAM write data.
- mem_rdata, in, DATA_WIDTH: RAM read data, registered, valid one cycle after the address is presented with mem_we=0.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs are 0: gnt_*, rvalid_*, rdata_*, mem_we, mem_addr, mem_wdata, busy. last_winner = B, so A wins the first tie.
- States: IDLE, ISSUE, READ, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the winner is the requester that is not last_winner.
  - On entry to ISSUE, register the winner's we, addr and wdata into the mem_* outputs and a winner flag. Update last_winner.
- ISSUE, one cycle:
  - mem_we = latched we; mem_addr and mem_wdata hold the latched values.
  - gnt_<winner> = 1 for exactly this cycle.
  - Next state: IDLE if the access is a write, READ if it is a read.
- READ, one cycle:
  - mem_we = 0; mem_addr is held.
  - On the closing edge, capture mem_rdata into rdata_<winner>.
  - Next state: RESP.
- RESP, one cycle:
  - rvalid_<winner> = 1. Next state: IDLE.
- mem_we is 1 only in ISSUE for a write; it is 0 in all other states.
- Latency from req sampled in IDLE:
  - gnt at +1 cycle.
  - Write committed at the end of the ISSUE cycle.
  - rvalid at +3 cycles.
- Throughput:
  - A write occupies 2 cycles (IDLE + ISSUE).
  - A read occupies 4 cycles.
  - Back-to-back requests always pass through IDLE.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - Inputs are sampled only in IDLE. Changes while busy are ignored until the next IDLE.
  - Dropping req before it is sampled withdraws the request. Once the request is latched it completes regardless of req.
  - A requester that keeps req high after gnt is treated as issuing a new request at the next IDLE.
- Fairness: with both requesters continuously requesting, grants alternate A, B, A, B. No requester waits for more than one other transaction.
- Non-winner outputs: the rdata_* of the non-winning requester is unchanged by a transaction.
- Wrap-around: addresses 0 to 2**ADDR_WIDTH-1 only; no out-of-range case exists.
- Reset mid-transaction: the transaction is aborted. No gnt or rvalid pulse follows. A write that had already reached ISSUE before reset was asserted may or may not have committed in the RAM; that is the RAM's concern.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs cnt_a and cnt_b, 8 bits each.
  - Each counter increments on every gnt pulse for its requester and wraps 255 -> 0.
  - Both counters reset to 0.
  - Adds input clr_stats, 1 bit, synchronous: zeroes both counters. clr_stats wins over a simultaneous increment.
- Not defined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset, then A writes 4'hA to address 2 (req_a=1, we_a=1) -> gnt_a at +1 cycle with mem_we=1, mem_addr=2, mem_wdata=A. busy returns to 0 at +2.
- After that write, B reads address 2 -> gnt_b at +1, rvalid_b at +3 with rdata_b=4'hA. rdata_a and rvalid_a stay 0.
- Both requesters write simultaneously (A: addr 1 = 4'h3, B: addr 1 = 4'h5), then A reads address 1 -> A granted first, then B, and the read returns 4'h5. With both req held continuously, gnt_a and gnt_b alternate strictly.
- Assert reset during READ of an A read -> all outputs 0 immediately, no rvalid_a afterwards. The next A read completes normally.
- Change addr_a from 1 to 3 while B's transaction is in progress, then keep A's inputs stable -> A's access uses addr 3.
- With ARB_STATS_EN: 300 A writes -> cnt_a=44 and cnt_b=0. Pulse clr_stats -> both counters 0 the next cycle.
